tk1_spi_slave: RTL and testbench

SPI mode 0 target that exchanges bytes with an external SPI master, one bit per sck period, MSB first. All SPI pins are oversampled and synchronised into the single system clock domain. Byte handshakes toward the tk1 register interface are valid/ready. It is the responder counterpart to the tk1 SPI master and is used for loopback testing and for a future host-side SPI link.

---
 rtl/tk1_spi_slave.sv | 135 +++++++++++++
 tb/tb_tk1_spi_slave.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tk1_spi_slave.sv
// tk1_spi_slave: SPI mode 0 target, pins oversampled into clk, valid/ready byte handshakes.
// Define TK1_SPI_SLAVE_RX_FIFO_EN for a 4-entry RX FIFO; otherwise RX storage is one register.
module tk1_spi_slave (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_ss,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_en,
    input  logic [7:0] tx_data,
    input  logic       tx_data_vld,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_data_vld,
    input  logic       rx_data_ack,
    input  logic       clr_status,
    output logic       rx_overrun,
    output logic       tx_underrun,
    output logic       busy
);
    typedef enum logic [1:0] {CTRL_IDLE, CTRL_LOAD, CTRL_SHIFT} ctrl_t;
    ctrl_t r_state, w_next;
    logic [2:0] r_ss, r_sck;
    logic [1:0] r_mosi;
    logic       r_sck_rise, r_sck_fall, r_ss_rise, r_ss_fall;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_sr, r_tx_sr, r_hold;
    logic       r_hold_full, r_rx_overrun, r_tx_underrun;
    logic       w_shift, w_load, w_rise, w_push, w_accept, w_pop, w_wr;
    logic [7:0] w_byte;

    // Edge pulses are registered, so every action lands one clk after detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ss       <= 3'b111;
            r_sck      <= 3'b000;
            r_mosi     <= 2'b00;
            r_sck_rise <= 1'b0;
            r_sck_fall <= 1'b0;
            r_ss_rise  <= 1'b0;
            r_ss_fall  <= 1'b0;
        end else begin
            r_ss       <= {r_ss[1:0], spi_ss};
            r_sck      <= {r_sck[1:0], spi_sck};
            r_mosi     <= {r_mosi[0], spi_mosi};
            r_sck_rise <= r_sck[1] & ~r_sck[2];
            r_sck_fall <= ~r_sck[1] & r_sck[2];
            r_ss_rise  <= r_ss[1] & ~r_ss[2];
            r_ss_fall  <= ~r_ss[1] & r_ss[2];
        end
    end

    always_comb begin
        w_next   = r_ss_rise ? CTRL_IDLE :
                   (r_state == CTRL_IDLE && r_ss_fall) ? CTRL_LOAD :
                   (r_state == CTRL_LOAD) ? CTRL_SHIFT : r_state;
        w_shift  = (r_state == CTRL_SHIFT) && !r_ss_rise;
        w_load   = (r_state == CTRL_LOAD) || (w_shift && r_sck_fall && r_bit_cnt == 3'd0);
        w_rise   = w_shift && r_sck_rise;
        w_push   = w_rise && r_bit_cnt == 3'd7;
        w_byte   = {r_rx_sr[6:0], r_mosi[1]};
        w_accept = tx_data_vld && !r_hold_full;
        w_pop    = rx_data_ack && rx_data_vld;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= CTRL_IDLE;
            r_bit_cnt     <= 3'd0;
            r_rx_sr       <= 8'h00;
            r_tx_sr       <= 8'h00;
            r_hold        <= 8'h00;
            r_hold_full   <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_rx_overrun  <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_bit_cnt     <= (r_ss_rise || r_state == CTRL_LOAD) ? 3'd0 :
                             w_rise ? r_bit_cnt + 3'd1 : r_bit_cnt;
            r_rx_sr       <= r_ss_rise ? 8'h00 : w_rise ? w_byte : r_rx_sr;
            r_tx_sr       <= w_load ? (r_hold_full ? r_hold : 8'hff) :
                             (w_shift && r_sck_fall) ? {r_tx_sr[6:0], 1'b0} : r_tx_sr;
            r_hold        <= w_accept ? tx_data : r_hold;
            r_hold_full   <= w_accept || (r_hold_full && !w_load);
            r_tx_underrun <= (w_load && !r_hold_full) || (r_tx_underrun && !clr_status);
            r_rx_overrun  <= (w_push && !w_wr) || (r_rx_overrun && !clr_status);
        end
    end

`ifdef TK1_SPI_SLAVE_RX_FIFO_EN
    logic [7:0] r_mem [4];
    logic [1:0] r_wp, r_rp;
    logic [2:0] r_fill;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_wr        = w_push && (r_fill != 3'd4 || w_pop);
    assign rx_data     = r_mem[r_rp];
    assign rx_data_vld = r_fill != 3'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
            r_wp   <= 2'd0;
            r_rp   <= 2'd0;
            r_fill <= 3'd0;
        end else begin
            if (w_wr) r_mem[r_wp] <= w_byte;
            r_wp   <= r_wp + {1'b0, w_wr};
            r_rp   <= r_rp + {1'b0, w_pop};
            r_fill <= r_fill + {2'b00, w_wr} - {2'b00, w_pop};
        end
    end
`else
    logic [7:0] r_rx_data;
    logic       r_rx_vld;
    assign w_wr        = w_push && (!r_rx_vld || w_pop);
    assign rx_data     = r_rx_data;
    assign rx_data_vld = r_rx_vld;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data <= 8'h00;
            r_rx_vld  <= 1'b0;
        end else begin
            r_rx_data <= w_wr ? w_byte : r_rx_data;
            r_rx_vld  <= w_wr || (r_rx_vld && !w_pop);
        end
    end
`endif

    assign spi_miso    = !r_ss[1] && r_tx_sr[7];
    assign spi_miso_en = !r_ss[1];
    assign busy        = !r_ss[1];
    assign tx_ready    = !r_hold_full;
    assign rx_overrun  = r_rx_overrun;
    assign tx_underrun = r_tx_underrun;
endmodule

// File: tb/tb_tk1_spi_slave.sv
// tb_tk1_spi_slave: random SPI mode 0 master against a transaction-level model of tk1_spi_slave.
module tb_tk1_spi_slave;
    logic       clk = 1'b0, reset = 1'b1;
    logic       spi_ss = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_en, tx_ready, rx_data_vld, rx_overrun, tx_underrun, busy;
    logic [7:0] tx_data = 8'h00, rx_data;
    logic       tx_data_vld = 1'b0, rx_data_ack = 1'b0, clr_status = 1'b0;
    int checks = 0, errors = 0;
`ifdef TK1_SPI_SLAVE_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int H = 16;

    logic [7:0] m_hold, m_sr;
    bit         m_hold_full, m_und, m_ovr;
    logic [7:0] m_rxq [$];

    tk1_spi_slave dut (
        .clk(clk), .reset(reset), .spi_ss(spi_ss), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_en(spi_miso_en), .tx_data(tx_data),
        .tx_data_vld(tx_data_vld), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_data_vld(rx_data_vld), .rx_data_ack(rx_data_ack), .clr_status(clr_status),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Next byte the target will present: the held byte, or 8'hff on underrun.
    function automatic logic [7:0] m_take();
        if (m_hold_full) begin
            m_hold_full = 1'b0;
            return m_hold;
        end
        m_und = 1'b1;
        return 8'hff;
    endfunction

    task automatic wr_tx(input logic [7:0] d);
        @(negedge clk);
        chk("tx_ready_pre", tx_ready, !m_hold_full);
        tx_data = d;
        tx_data_vld = 1'b1;
        @(negedge clk);
        tx_data_vld = 1'b0;
        if (!m_hold_full) begin
            m_hold = d;
            m_hold_full = 1'b1;
        end
        chk("tx_ready_post", tx_ready, 0);
    endtask

    task automatic ss_low();
        spi_ss = 1'b0;
        m_sr = m_take();
        clk_n(H);
        chk("busy_sel", busy, 1);
        chk("miso_en_sel", spi_miso_en, 1);
        chk("tx_ready_load", tx_ready, !m_hold_full);
    endtask

    task automatic ss_high();
        clk_n(H);
        spi_ss = 1'b1;
        clk_n(8);
    endtask

    task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit mid, input logic [7:0] md);
        logic [7:0] mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            clk_n(H);
            spi_sck = 1'b1;
            mi[7-i] = spi_miso;
            clk_n(H);
            spi_sck = 1'b0;
            if (mid && i == 3) wr_tx(md);
        end
        if (nbits == 8) begin
            chk("master_rx", mi, m_sr);
            m_sr = m_take();
            if (m_rxq.size() < DEPTH) m_rxq.push_back(mo);
            else m_ovr = 1'b1;
        end
    endtask

    task automatic status();
        @(negedge clk);
        chk("rx_vld", rx_data_vld, m_rxq.size() > 0);
        if (m_rxq.size() > 0) chk("rx_data", rx_data, m_rxq[0]);
        chk("rx_overrun", rx_overrun, m_ovr);
        chk("tx_underrun", tx_underrun, m_und);
        chk("tx_ready", tx_ready, !m_hold_full);
        chk("busy_idle", busy, 0);
    endtask

    task automatic pop_all();
        while (m_rxq.size() > 0) begin
            @(negedge clk);
            chk("pop_vld", rx_data_vld, 1);
            chk("pop_data", rx_data, m_rxq[0]);
            rx_data_ack = 1'b1;
            @(negedge clk);
            rx_data_ack = 1'b0;
            void'(m_rxq.pop_front());
        end
        @(negedge clk);
        chk("empty_vld", rx_data_vld, 0);
    endtask

    task automatic clr();
        @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        m_und = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        spi_ss = 1'b1;
        spi_sck = 1'b0;
        spi_mosi = 1'b0;
        clk_n(3);
        reset = 1'b0;
        m_hold_full = 1'b0;
        m_und = 1'b0;
        m_ovr = 1'b0;
        m_rxq.delete();
        @(negedge clk);
        chk("rst_miso", spi_miso, 0);
        chk("rst_miso_en", spi_miso_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_vld", rx_data_vld, 0);
        chk("rst_ovr", rx_overrun, 0);
        chk("rst_und", tx_underrun, 0);
    endtask

    initial begin
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_miso_en", spi_miso_en, 0);
        end
        // Single byte; a second byte is parked mid-byte so the boundary reload is not an underrun.
        wr_tx(8'ha5);
        ss_low();
        spi_byte(8'h3c, 8, 1'b1, 8'h5a);
        ss_high();
        status();
        pop_all();
        // Back-to-back bytes, next tx byte loaded mid-byte each time.
        wr_tx(8'($urandom));
        ss_low();
        spi_byte(8'($urandom), 8, 1'b1, 8'($urandom));
        spi_byte(8'($urandom), 8, 1'b1, 8'($urandom));
        ss_high();
        status();
        pop_all();
        clr();
        status();
        // Empty holding register at the start boundary.
        ss_low();
        spi_byte(8'($urandom), 8, 1'b0, 8'h00);
        ss_high();
        status();
        clr();
        status();
        pop_all();
        // Five bytes with no acknowledge.
        ss_low();
        for (int k = 0; k < 5; k++) spi_byte(8'($urandom), 8, 1'b0, 8'h00);
        ss_high();
        status();
        pop_all();
        clr();
        // Aborted partial byte followed by a full one.
        wr_tx(8'h42);
        ss_low();
        spi_byte(8'($urandom), 3, 1'b0, 8'h00);
        ss_high();
        status();
        ss_low();
        spi_byte(8'h81, 8, 1'b0, 8'h00);
        ss_high();
        status();
        pop_all();
        clr();
        // A write while the holding register is full is ignored.
        wr_tx(8'h11);
        wr_tx(8'h22);
        ss_low();
        spi_byte(8'($urandom), 8, 1'b0, 8'h00);
        ss_high();
        status();
        pop_all();
        clr();
        for (int t = 0; t < 6; t++) begin
            if ($urandom_range(0, 1) == 1) wr_tx(8'($urandom));
            ss_low();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                spi_byte(8'($urandom), 8, 1'($urandom_range(0, 1)), 8'($urandom));
            ss_high();
            status();
            pop_all();
            clr();
            status();
        end
        // Reset in the middle of a byte.
        b = 8'($urandom);
        wr_tx(b);
        ss_low();
        spi_byte(b, 4, 1'b0, 8'h00);
        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
